// File: rtl/arb_requester_pkg.sv
// Shared types and constants for the arbiter requester client.
package arb_requester_pkg;

    // Requester FSM state codes.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StXfer = 2'd2,
        StRel  = 2'd3
    } state_e;

    // Width of one queued command: {len, data}.
    function automatic int unsigned cmd_w(input int unsigned len_w, input int unsigned data_w);
        return len_w + data_w;
    endfunction

    localparam int unsigned CMD_W = cmd_w(4, 8);

endpackage

// File: rtl/arb_requester_if.sv
// Command, arbiter and beat-stream signals of one requester client.
interface arb_requester_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] cmd_data;
    logic              req;
    logic              grant;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              done;
    logic              starve;
    logic              err_spurious;
    logic [CNT_W-1:0]  fifo_count;

    // The requester block itself.
    modport master (
        input  cmd_valid, cmd_len, cmd_data, grant,
        output cmd_ready, req, out_valid, out_data, done, starve, err_spurious, fifo_count
    );

    // Local command source, arbiter and beat consumer.
    modport slave (
        output cmd_valid, cmd_len, cmd_data, grant,
        input  cmd_ready, req, out_valid, out_data, done, starve, err_spurious, fifo_count
    );
endinterface

// File: rtl/arb_requester_cmd_fifo.sv
// Synchronous command FIFO with occupancy output; head is read combinationally.
module arb_requester_cmd_fifo
    import arb_requester_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = CMD_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;

    // Storage array, written on push; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (cnt == (PTR_W + 1)'(DEPTH));
    assign count = cnt;

endmodule

// File: rtl/arb_requester.sv
// Requester client: queues burst commands, requests the arbiter, streams beats
// while granted, releases for one cycle per burst, and flags starvation and
// spurious grants.
module arb_requester
    import arb_requester_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input logic               clk,
    input logic               rst,
    arb_requester_if.master   bus
);
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned C_W    = cmd_w(LEN_W, DATA_W);
    localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e              state;
    logic                req;
    logic                done;
    logic                starve;
    logic                err_spurious;
    logic [LEN_W-1:0]    beat_rem;
    logic [LEN_W-1:0]    beat_idx;
    logic [WAIT_W-1:0]   wait_cnt;

    logic                cmd_ready;
    logic                full;
    logic                push;
    logic                pop;
    logic                beat;
    logic [C_W-1:0]      head;
    logic [LEN_W-1:0]    head_len;
    logic [DATA_W-1:0]   head_data;
    logic [CNT_W-1:0]    count;

    assign cmd_ready = !full && !rst;
    assign push      = bus.cmd_valid && cmd_ready;
    // req is only high in REQ/XFER, so a granted cycle there is a beat.
    assign beat      = req && bus.grant;
    assign pop       = beat && (beat_rem == '0);
    assign head_len  = head[C_W-1 -: LEN_W];
    assign head_data = head[DATA_W-1:0];

    arb_requester_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (C_W)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({bus.cmd_len, bus.cmd_data}),
        .rdata (head),
        .full  (full),
        .count (count)
    );

    // Burst FSM with registered req/done, beat counters and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            req          <= 1'b0;
            done         <= 1'b0;
            starve       <= 1'b0;
            err_spurious <= 1'b0;
            beat_rem     <= '0;
            beat_idx     <= '0;
            wait_cnt     <= '0;
        end else begin
            done <= 1'b0;
            if (bus.grant && !req) begin
                err_spurious <= 1'b1;
            end
            case (state)
                StIdle: begin
                    if (count != '0) begin
                        state    <= StReq;
                        req      <= 1'b1;
                        beat_rem <= head_len;
                        beat_idx <= '0;
                        wait_cnt <= '0;
                    end
                end
                StReq, StXfer: begin
                    if (bus.grant) begin
                        beat_idx <= beat_idx + 1'b1;
                        beat_rem <= beat_rem - 1'b1;
                        if (beat_rem == '0) begin
                            state <= StRel;
                            req   <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= StXfer;
                        end
                    end else if (state == StReq) begin
                        // Starve is raised on the edge that brings wait_cnt to TIMEOUT-1.
                        if (wait_cnt != WAIT_W'(TIMEOUT - 1)) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                        if (wait_cnt >= WAIT_W'(TIMEOUT - 2)) begin
                            starve <= 1'b1;
                        end
                    end
                end
                StRel: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign bus.cmd_ready    = cmd_ready;
    assign bus.req          = req;
    assign bus.out_valid    = beat;
    assign bus.out_data     = head_data + DATA_W'(beat_idx);
    assign bus.done         = done;
    assign bus.starve       = starve;
    assign bus.err_spurious = err_spurious;
    assign bus.fifo_count   = count;

endmodule
